instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Packs decoded RISC-V instruction fields (format, opcode, registers, functs, 32-bit immediate) into a 32-bit RV32I instruction word and streams it, with an auto-incrementing word address, to the instruction-memory write port. It performs the inverse of the core's immediate decode, scattering immediate bits into the I/S/B/U/J layouts. It sits between the test/boot loader and instruction memory. It is a registered, valid/ready pipeline stage with range checking and a fill limit.

## Interface
- ADDR_W, 8, instruction-memory word-address width; the memory holds 2^ADDR_W words
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- clear_in  input  1  synchronous restart: flush the output, zero the address, clear the flags
- valid_in  input  1  input fields valid
- ready_out  output  1  encoder can accept fields
- format_in  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- opcode_in  input  7  opcode, placed in bits [6:0]
- rd_in, rs1_in, rs2_in  input  5 each  register indices
- funct3_in  input  3  funct3
- funct7_in  input  7  funct7 (R only)
- immediate_in  input  32  byte-offset / value immediate, sign-extended (U: upper value with low 12 bits zero)
- valid_out  output  1  instruction_out/address_out valid
- ready_in  input  1  memory accepts the word
- instruction_out  output  32  encoded word
- address_out  output  ADDR_W  word address for this word
- error_out  output  1  sticky: a rejected input was seen
- full_out  output  1  sticky: the last address has been written

## Operation
- Encoding (unused fields ignored):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Range rules:
  - I/S: immediate_in[31:11] all equal.
  - B: immediate_in[31:12] all equal and bit0=0.
  - J: immediate_in[31:20] all equal and bit0=0.
  - U: immediate_in[11:0]=0.
  - R: always legal.
  - Format 6/7: always illegal.
- Rejected input:
  - The input is consumed.
  - No word is emitted.
  - The address does not advance.
  - error_out is set.
- Address counter:
  - Starts at 0 and is captured into address_out with each accepted legal input.
  - Increments by 1 on each accepted legal input.
  - When the word at address 2^ADDR_W−1 completes its output handshake, full_out is set.
  - While full_out is set, ready_out=0 until clear_in or reset. There is no silent wrap.
- clear_in:
  - Drops any pending output word.
  - Sets address to 0 and clears error_out and full_out.
  - ready_out=0 during the clear_in cycle, so no input is accepted.
  - clear_in has priority over all handshakes in the same cycle.

## Timing
- Reset values: valid_out=0, instruction_out=0, address_out=0, error_out=0, full_out=0. ready_out=1 once rst_n_in is released.
- Reset asserted mid-transfer discards the pending word immediately, asynchronously.
- Latency: an input accepted at edge N gives valid_out=1 with the word after edge N.
- Input handshake: transfer when valid_in && ready_out at a rising edge.
- Output handshake: transfer when valid_out && ready_in at a rising edge.
- Single output register:
  - ready_out = !full_out && !clear_in && (!valid_out || ready_in).
  - Back-to-back throughput is 1 word/cycle while ready_in=1.
- Output stability: while valid_out && !ready_in, instruction_out and address_out are held stable.
- Simultaneous output transfer and new input: the register reloads in the same edge with no bubble.
- error_out rises the cycle after the rejected input is accepted.
- full_out rises the cycle after the final output handshake.

## Configuration
- ENCODER_RANGE_CHECK_EN defined:
  - Range rules enforced as above.
  - error_out is functional.
- ENCODER_RANGE_CHECK_EN undefined:
  - No range checking.
  - Immediates are truncated to the field bits; the B/J bit0 is ignored.
  - Format 6/7 encodes as R.
  - error_out is tied to 0.

## Test plan
- I-type: format=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 → instruction_out=0x00500093, address_out=0, valid_out one cycle after acceptance.
- B/J/U sequence:
  - B: opcode=0x63, rs1=1, rs2=2, funct3=0, imm=8 → 0x00208463 @ address 0.
  - J: opcode=0x6F, rd=1, imm=16 → 0x010000EF @ address 1.
  - U: opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7 @ address 2.
- Range error: I-type imm=0x800, then J-type imm=3 → no valid_out for either, error_out=1, address unchanged; a following legal word still appears at the same address.
- Backpressure: stream 4 words with ready_in low for 3 cycles mid-stream → outputs held stable, ready_out=0 while stalled, no loss or duplication, 1 word/cycle otherwise.
- Fill limit with ADDR_W=2: 4 legal words handshaked → full_out=1, ready_out=0; clear_in → full_out=0, next word goes to address 0.
- Reset while valid_out=1 and ready_in=0 → valid_out=0 and address_out=0 immediately; repeat with the macro undefined, imm=0x800 → word emitted with imm[11:0]=0x800, error_out=0.

Source files
------------

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded RV32I fields into instruction words streamed to imem (optional ENCODER_RANGE_CHECK_EN)
module instruction_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              clear_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [2:0]        format_in,
  input  logic [6:0]        opcode_in,
  input  logic [4:0]        rd_in,
  input  logic [4:0]        rs1_in,
  input  logic [4:0]        rs2_in,
  input  logic [2:0]        funct3_in,
  input  logic [6:0]        funct7_in,
  input  logic [31:0]       immediate_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [31:0]       instruction_out,
  output logic [ADDR_W-1:0] address_out,
  output logic              error_out,
  output logic              full_out
);
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              error_q, error_d;
  logic              full_q, full_d;
  logic [31:0]       word;
  logic [31:0]       imm;
  logic              legal;
  logic              accept;
  assign imm = immediate_in;
  // cnt_q[ADDR_W] marks that the last address has been issued, so nothing can wrap to 0 before full_out rises
  assign ready_out = !full_q && !cnt_q[ADDR_W] && !clear_in && (!valid_q || ready_in);
  assign accept = valid_in && ready_out;
  // scatter fields into the format layout; illegal formats fall back to R
  always_comb begin
    word = {funct7_in, rs2_in, rs1_in, funct3_in, rd_in, opcode_in};
    case (format_in)
      3'd1:    word = {imm[11:0], rs1_in, funct3_in, rd_in, opcode_in};
      3'd2:    word = {imm[11:5], rs2_in, rs1_in, funct3_in, imm[4:0], opcode_in};
      3'd3:    word = {imm[12], imm[10:5], rs2_in, rs1_in, funct3_in, imm[4:1], imm[11], opcode_in};
      3'd4:    word = {imm[31:12], rd_in, opcode_in};
      3'd5:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd_in, opcode_in};
      default: word = {funct7_in, rs2_in, rs1_in, funct3_in, rd_in, opcode_in};
    endcase
  end
`ifdef ENCODER_RANGE_CHECK_EN
  logic s11, s12, s20;
  assign s11 = &imm[31:11] || ~|imm[31:11];
  assign s12 = &imm[31:12] || ~|imm[31:12];
  assign s20 = &imm[31:20] || ~|imm[31:20];
  // immediate must fit its field exactly; formats 6/7 never legal
  assign legal = (format_in == 3'd1 || format_in == 3'd2) ? s11 :
                 (format_in == 3'd3) ? (s12 && !imm[0]) :
                 (format_in == 3'd4) ? (imm[11:0] == 12'd0) :
                 (format_in == 3'd5) ? (s20 && !imm[0]) :
                 (format_in == 3'd0);
`else
  assign legal = 1'b1;
`endif
  // next state: clear wins, otherwise drain on output handshake and reload on legal accept
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    full_d  = full_q;
    if (clear_in) begin
      valid_d = 1'b0;
      addr_d  = '0;
      cnt_d   = '0;
      error_d = 1'b0;
      full_d  = 1'b0;
    end else begin
      if (valid_q && ready_in) begin
        valid_d = 1'b0;
        full_d  = full_q || (&addr_q);
      end
      if (accept && legal) begin
        valid_d = 1'b1;
        instr_d = word;
        addr_d  = cnt_q[ADDR_W-1:0];
        cnt_d   = cnt_q + 1'b1;
      end
      error_d = error_q || (accept && !legal);
    end
  end
  // output register and address counter, discarded immediately on reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      full_q  <= full_d;
    end
  end
  assign valid_out       = valid_q;
  assign instruction_out = instr_q;
  assign address_out     = addr_q;
  assign error_out       = error_q;
  assign full_out        = full_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed bench for instruction_encoder built with ADDR_W=2
module tb_instruction_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_in;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  format_in;
  logic [6:0]  opcode_in;
  logic [4:0]  rd_in, rs1_in, rs2_in;
  logic [2:0]  funct3_in;
  logic [6:0]  funct7_in;
  logic [31:0] immediate_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] instruction_out;
  logic [1:0]  address_out;
  logic        error_out;
  logic        full_out;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  instruction_encoder #(.ADDR_W(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear_in), .valid_in(valid_in), .ready_out(ready_out),
    .format_in(format_in), .opcode_in(opcode_in), .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .funct3_in(funct3_in), .funct7_in(funct7_in), .immediate_in(immediate_in), .valid_out(valid_out),
    .ready_in(ready_in), .instruction_out(instruction_out), .address_out(address_out),
    .error_out(error_out), .full_out(full_out)
  );
  task automatic put(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    valid_in = 1'b1; format_in = f; opcode_in = op; rd_in = rd; rs1_in = rs1; rs2_in = rs2;
    funct3_in = f3; funct7_in = 7'h0; immediate_in = imm;
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_clear;
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    vectors += 5;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid_out); end
    if (instruction_out !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", instruction_out); end
    if (address_out !== 2'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", address_out); end
    if (error_out !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b want 0", error_out); end
    if (full_out !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full_out); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ready_out !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready_out); end
  endtask
  task automatic test_i_type;
    ready_in = 1'b0;
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    tick();
    valid_in = 1'b0;
    vectors += 4;
    if (valid_out !== 1'b1) begin miscompares++; $display("FAIL i_valid got %b want 1", valid_out); end
    if (instruction_out !== 32'h00500093) begin miscompares++; $display("FAIL i_instr got %h want 00500093", instruction_out); end
    if (address_out !== 2'd0) begin miscompares++; $display("FAIL i_addr got %0d want 0", address_out); end
    if (ready_out !== 1'b0) begin miscompares++; $display("FAIL i_stall_ready got %b want 0", ready_out); end
    ready_in = 1'b1;
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL i_drain got %b want 0", valid_out); end
    do_clear();
  endtask
  task automatic test_bju;
    ready_in = 1'b1;
    put(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
    tick();
    vectors += 3;
    if (valid_out !== 1'b1) begin miscompares++; $display("FAIL b_valid got %b want 1", valid_out); end
    if (instruction_out !== 32'h00208463) begin miscompares++; $display("FAIL b_instr got %h want 00208463", instruction_out); end
    if (address_out !== 2'd0) begin miscompares++; $display("FAIL b_addr got %0d want 0", address_out); end
    put(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd16);
    tick();
    vectors += 2;
    if (instruction_out !== 32'h010000EF) begin miscompares++; $display("FAIL j_instr got %h want 010000ef", instruction_out); end
    if (address_out !== 2'd1) begin miscompares++; $display("FAIL j_addr got %0d want 1", address_out); end
    put(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
    tick();
    vectors += 2;
    if (instruction_out !== 32'h123452B7) begin miscompares++; $display("FAIL u_instr got %h want 123452b7", instruction_out); end
    if (address_out !== 2'd2) begin miscompares++; $display("FAIL u_addr got %0d want 2", address_out); end
    valid_in = 1'b0;
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL bju_drain got %b want 0", valid_out); end
    do_clear();
  endtask
  task automatic test_range;
    ready_in = 1'b1;
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
    tick();
`ifdef ENCODER_RANGE_CHECK_EN
    vectors += 2;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rng_i_valid got %b want 0", valid_out); end
    if (error_out !== 1'b1) begin miscompares++; $display("FAIL rng_i_error got %b want 1", error_out); end
    put(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
    tick();
    vectors += 2;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rng_j_valid got %b want 0", valid_out); end
    if (error_out !== 1'b1) begin miscompares++; $display("FAIL rng_j_error got %b want 1", error_out); end
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    tick();
    vectors += 3;
    if (valid_out !== 1'b1) begin miscompares++; $display("FAIL rng_next_valid got %b want 1", valid_out); end
    if (instruction_out !== 32'h00500093) begin miscompares++; $display("FAIL rng_next_instr got %h want 00500093", instruction_out); end
    if (address_out !== 2'd0) begin miscompares++; $display("FAIL rng_next_addr got %0d want 0", address_out); end
`else
    vectors += 4;
    if (valid_out !== 1'b1) begin miscompares++; $display("FAIL trunc_i_valid got %b want 1", valid_out); end
    if (instruction_out !== 32'h80000093) begin miscompares++; $display("FAIL trunc_i_instr got %h want 80000093", instruction_out); end
    if (address_out !== 2'd0) begin miscompares++; $display("FAIL trunc_i_addr got %0d want 0", address_out); end
    if (error_out !== 1'b0) begin miscompares++; $display("FAIL trunc_i_error got %b want 0", error_out); end
    put(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
    tick();
    vectors += 3;
    if (instruction_out !== 32'h002000EF) begin miscompares++; $display("FAIL trunc_j_instr got %h want 002000ef", instruction_out); end
    if (address_out !== 2'd1) begin miscompares++; $display("FAIL trunc_j_addr got %0d want 1", address_out); end
    if (error_out !== 1'b0) begin miscompares++; $display("FAIL trunc_j_error got %b want 0", error_out); end
`endif
    valid_in = 1'b0;
    tick();
    do_clear();
    vectors++;
    if (error_out !== 1'b0) begin miscompares++; $display("FAIL clear_error got %b want 0", error_out); end
  endtask
  task automatic test_backpressure_fill;
    ready_in = 1'b1;
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    tick();
    vectors += 2;
    if (instruction_out !== 32'h00000093) begin miscompares++; $display("FAIL bp_w0 got %h want 00000093", instruction_out); end
    if (address_out !== 2'd0) begin miscompares++; $display("FAIL bp_w0_addr got %0d want 0", address_out); end
    ready_in = 1'b0;
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors += 4;
      if (ready_out !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready[%0d] got %b want 0", i, ready_out); end
      if (valid_out !== 1'b1) begin miscompares++; $display("FAIL bp_stall_valid[%0d] got %b want 1", i, valid_out); end
      if (instruction_out !== 32'h00000093) begin miscompares++; $display("FAIL bp_stall_instr[%0d] got %h want 00000093", i, instruction_out); end
      if (address_out !== 2'd0) begin miscompares++; $display("FAIL bp_stall_addr[%0d] got %0d want 0", i, address_out); end
    end
    ready_in = 1'b1;
    for (int k = 1; k < 4; k++) begin
      put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, k);
      tick();
      vectors += 3;
      if (valid_out !== 1'b1) begin miscompares++; $display("FAIL bp_w%0d_valid got %b want 1", k, valid_out); end
      if (instruction_out !== ((k << 20) | 32'h93)) begin miscompares++; $display("FAIL bp_w%0d got %h want %h", k, instruction_out, (k << 20) | 32'h93); end
      if (address_out !== k[1:0]) begin miscompares++; $display("FAIL bp_w%0d_addr got %0d want %0d", k, address_out, k); end
    end
    valid_in = 1'b0;
    tick();
    vectors += 3;
    if (full_out !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b want 1", full_out); end
    if (ready_out !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b want 0", ready_out); end
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL fill_valid got %b want 0", valid_out); end
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd9);
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL fill_blocked got %b want 0", valid_out); end
    clear_in = 1'b1;
    #1;
    vectors++;
    if (ready_out !== 1'b0) begin miscompares++; $display("FAIL clear_ready got %b want 0", ready_out); end
    tick();
    clear_in = 1'b0;
    #1;
    vectors += 2;
    if (full_out !== 1'b0) begin miscompares++; $display("FAIL clear_full got %b want 0", full_out); end
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL clear_no_word got %b want 0", valid_out); end
    tick();
    vectors += 3;
    if (valid_out !== 1'b1) begin miscompares++; $display("FAIL after_clear_valid got %b want 1", valid_out); end
    if (instruction_out !== 32'h00900093) begin miscompares++; $display("FAIL after_clear_instr got %h want 00900093", instruction_out); end
    if (address_out !== 2'd0) begin miscompares++; $display("FAIL after_clear_addr got %0d want 0", address_out); end
    valid_in = 1'b0;
    tick();
  endtask
  task automatic test_async_reset;
    ready_in = 1'b0;
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    tick();
    valid_in = 1'b0;
    vectors += 2;
    if (valid_out !== 1'b1) begin miscompares++; $display("FAIL ar_pre_valid got %b want 1", valid_out); end
    if (address_out !== 2'd1) begin miscompares++; $display("FAIL ar_pre_addr got %0d want 1", address_out); end
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b want 0", valid_out); end
    if (address_out !== 2'd0) begin miscompares++; $display("FAIL ar_addr got %0d want 0", address_out); end
    if (instruction_out !== 32'h0) begin miscompares++; $display("FAIL ar_instr got %h want 0", instruction_out); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ready_out !== 1'b1) begin miscompares++; $display("FAIL ar_ready got %b want 1", ready_out); end
  endtask
  initial begin
    rst_n = 1'b0; clear_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    format_in = 3'd0; opcode_in = 7'h0; rd_in = 5'd0; rs1_in = 5'd0; rs2_in = 5'd0;
    funct3_in = 3'd0; funct7_in = 7'h0; immediate_in = 32'h0;
    test_reset();
    test_i_type();
    test_bju();
    test_range();
    test_backpressure_fill();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
